// File: rtl/inst_fetch_if.sv
// Instruction-memory read port shared by inst_fetch (master) and the memory side (slave).
// Optional perf counters in inst_fetch are enabled with INST_FETCH_PERF_CNT_EN.
interface inst_fetch_if #(
  parameter int ADDR_W = 32
);
  // Handshake: mem_req/mem_addr are held stable until a cycle with mem_gnt high;
  // that cycle transfers the request. Each granted request is answered by exactly
  // one mem_rvalid pulse carrying mem_rdata, no earlier than the cycle after mem_gnt.
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/inst_fetch.sv
// Wavefront instruction fetcher: one outstanding read at a time into a prefetch FIFO,
// FIFO head registered onto inst for the decoder. INST_FETCH_PERF_CNT_EN adds counters.
module inst_fetch #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic [15:0]       num_inst,
  input  logic [5:0]        start_wf,
  input  logic              flush,
  inst_fetch_if.master      mem,
  output logic [31:0]       inst,
  output logic [5:0]        wavefront_num,
  input  logic              decoder_stall,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state_dbg
`ifdef INST_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [15:0]        num_q, num_d;
  logic [15:0]        issued_q, issued_d;
  logic [15:0]        rcvd_q, rcvd_d;
  logic               outst_q, outst_d;
  logic [31:0]        fifo_q [FIFO_DEPTH];
  logic [31:0]        fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        inst_q, inst_d;
  logic [5:0]         wf_q, wf_d;
  logic               mem_req_q, mem_req_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic launch, granted, returned, push, pop;

  always_comb begin
    launch   = start && (state_q == S_IDLE || state_q == S_DONE);
    granted  = (state_q == S_FETCH) && mem_req_q && mem.mem_gnt;
    returned = outst_q && mem.mem_rvalid;
    push     = returned && (state_q == S_FETCH) && !flush;
    pop      = !decoder_stall && (count_q != '0);
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    num_d    = num_q;
    issued_d = issued_q;
    rcvd_d   = rcvd_q;
    outst_d  = outst_q;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    inst_d   = inst_q;
    wf_d     = wf_q;

    if (push) begin
      fifo_d[wr_ptr_q] = mem.mem_rdata;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      rcvd_d           = rcvd_q + 16'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    // Pop reads the pre-push head, so a word pushed into an empty FIFO leaves next cycle.
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (!decoder_stall) begin
      inst_d = pop ? fifo_q[rd_ptr_q] : 32'h0;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          pc_d     = start_pc;
          num_d    = num_inst;
          wf_d     = start_wf;
          issued_d = '0;
          rcvd_d   = '0;
          state_d  = (num_inst == 16'd0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (flush) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
          inst_d   = 32'h0;
          // A read granted now or earlier and not yet returned must be drained in FLUSH.
          outst_d  = (outst_q && !mem.mem_rvalid) || granted;
          state_d  = outst_d ? S_FLUSH : S_IDLE;
        end else begin
          if (returned) outst_d = 1'b0;
          if (granted) begin
            pc_d     = pc_q + ADDR_W'(4);
            issued_d = issued_q + 16'd1;
            outst_d  = 1'b1;
          end
          if (rcvd_d == num_q && count_d == '0) state_d = S_DONE;
        end
      end
      S_FLUSH: begin
        if (returned) begin
          outst_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    mem_req_d = (state_d == S_FETCH) && !outst_d && (issued_d < num_d) &&
                (count_d < CNT_W'(FIFO_DEPTH));
    busy_d    = (state_d == S_FETCH) || (state_d == S_FLUSH);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      num_q     <= '0;
      issued_q  <= '0;
      rcvd_q    <= '0;
      outst_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      inst_q    <= 32'h0;
      wf_q      <= '0;
      mem_req_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      num_q     <= num_d;
      issued_q  <= issued_d;
      rcvd_q    <= rcvd_d;
      outst_q   <= outst_d;
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      inst_q    <= inst_d;
      wf_q      <= wf_d;
      mem_req_q <= mem_req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign mem.mem_req    = mem_req_q;
  assign mem.mem_addr   = pc_q;
  assign inst           = inst_q;
  assign wavefront_num  = wf_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign state_dbg      = state_q;

`ifdef INST_FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (launch) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if (busy_q && decoder_stall && stall_cnt_q != '1)
        stall_cnt_d = stall_cnt_q + 32'd1;
      if (busy_q && !decoder_stall && count_q == '0 && bubble_cnt_q != '1)
        bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios then randomized launches, checked against a
// queue-based model of the instruction stream and a simple responding memory.
module tb_inst_fetch;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] start_pc;
  logic [15:0]   num_inst;
  logic [5:0]    start_wf;
  logic          flush;
  logic [31:0]   inst;
  logic [5:0]    wavefront_num;
  logic          decoder_stall;
  logic          busy;
  logic          done;
  logic [1:0]    state_dbg;
`ifdef INST_FETCH_PERF_CNT_EN
  logic [31:0]   stall_cnt, bubble_cnt;
  int            exp_stall_cnt, exp_bubble_cnt;
`endif

  always #5 clk = ~clk;

  inst_fetch_if #(.ADDR_W(AW)) mem_bus ();

  inst_fetch #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
    .num_inst(num_inst), .start_wf(start_wf), .flush(flush), .mem(mem_bus),
    .inst(inst), .wavefront_num(wavefront_num), .decoder_stall(decoder_stall),
    .busy(busy), .done(done), .state_dbg(state_dbg)
`ifdef INST_FETCH_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: expected word stream plus counts of words received/delivered.
  logic [31:0]   exp_q[$];
  logic [AW-1:0] exp_addr;
  logic [31:0]   prev_inst;
  logic [5:0]    exp_wf;
  int            n_rv, n_del, n_num;
  bit            exp_done, exp_busy, flushing, discard;
  // Responding memory.
  bit            rv_pending = 1'b0;
  int            rv_wait, req_age, gnt_delay, rv_delay;
  logic [AW-1:0] rv_addr;
  bit            rand_mem;
  int            grants, req_cycles;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic pick_delays();
    gnt_delay = int'($urandom_range(0, 2));
    rv_delay  = int'($urandom_range(1, 3));
  endtask

  task automatic model_reset();
    exp_q.delete();
    n_rv = 0; n_del = 0; n_num = 0;
    exp_done = 1'b0; exp_busy = 1'b0; exp_wf = '0;
    flushing = 1'b0; discard = 1'b1; prev_inst = '0;
`ifdef INST_FETCH_PERF_CNT_EN
    exp_stall_cnt = 0; exp_bubble_cnt = 0;
`endif
  endtask

  task automatic launch_model();
    exp_q.delete();
    for (int k = 0; k < int'(num_inst); k++) exp_q.push_back(mem_word(start_pc + AW'(4 * k)));
    n_num = int'(num_inst); n_rv = 0; n_del = 0;
    exp_addr = start_pc; exp_wf = start_wf;
    exp_done = (num_inst == 16'd0); exp_busy = (num_inst != 16'd0);
    flushing = 1'b0; discard = 1'b0;
    req_age = 0; grants = 0; req_cycles = 0;
`ifdef INST_FETCH_PERF_CNT_EN
    exp_stall_cnt = 0; exp_bubble_cnt = 0;
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_inst"},     64'(inst), 64'(0));
    check({tag, "_mem_req"},  64'(mem_bus.mem_req), 64'(0));
    check({tag, "_mem_addr"}, 64'(mem_bus.mem_addr), 64'(0));
    check({tag, "_busy"},     64'(busy), 64'(0));
    check({tag, "_done"},     64'(done), 64'(0));
    check({tag, "_wf"},       64'(wavefront_num), 64'(0));
    check({tag, "_state"},    64'(state_dbg), 64'(ST_IDLE));
  endtask

  // One clock cycle: drive inputs (called just after a rising edge), step the model, check.
  task automatic cycle(input bit stall, input bit st, input bit fl);
    bit            gnt, rv, req_seen, was_idle, busy_before;
    logic [AW-1:0] addr_seen;
    logic [31:0]   w;
    int            occ_before;
    req_seen  = mem_bus.mem_req;
    addr_seen = mem_bus.mem_addr;
    gnt = req_seen && (req_age >= gnt_delay);
    rv  = rv_pending && (rv_wait == 0);
    decoder_stall = stall; start = st; flush = fl;
    mem_bus.mem_gnt    = gnt;
    mem_bus.mem_rvalid = rv;
    mem_bus.mem_rdata  = rv ? mem_word(rv_addr) : $urandom();
    if (req_seen) begin
      req_cycles++;
      check("one_outstanding", 64'(rv_pending), 64'(0));
      check("req_fifo_room", 64'(n_rv - n_del < DEPTH), 64'(1));
      check("req_addr", 64'(addr_seen), 64'(exp_addr));
    end
    occ_before  = n_rv - n_del;
    was_idle    = !exp_busy;
    busy_before = exp_busy;
    @(posedge clk);
    #1;
    if (rv) begin
      rv_pending = 1'b0;
      if (!discard) n_rv++;
    end else if (rv_pending && rv_wait > 0) begin
      rv_wait--;
    end
    if (gnt) begin
      grants++;
      rv_pending = 1'b1; rv_wait = rv_delay - 1; rv_addr = addr_seen;
      req_age = 0; exp_addr = exp_addr + AW'(4);
      if (rand_mem) pick_delays();
    end else if (req_seen) begin
      req_age++;
    end
`ifdef INST_FETCH_PERF_CNT_EN
    if (busy_before && stall) exp_stall_cnt++;
    if (busy_before && !stall && occ_before == 0) exp_bubble_cnt++;
`endif
    if (fl && exp_busy && !flushing) begin
      exp_q.delete(); n_rv = 0; n_del = 0;
      check("flush_inst", 64'(inst), 64'(0));
      if (rv_pending) begin
        flushing = 1'b1; discard = 1'b1;
      end else begin
        exp_busy = 1'b0;
      end
    end else if (flushing) begin
      check("flushing_inst", 64'(inst), 64'(0));
      if (rv) begin
        flushing = 1'b0; exp_busy = 1'b0;
      end
    end else if (stall) begin
      check("inst_hold", 64'(inst), 64'(prev_inst));
    end else if (occ_before > 0 && exp_q.size() > 0) begin
      w = exp_q.pop_front();
      check("inst_order", 64'(inst), 64'(w));
      n_del++;
      if (exp_busy && n_del == n_num) begin
        exp_done = 1'b1; exp_busy = 1'b0;
      end
    end else begin
      check("inst_nop", 64'(inst), 64'(0));
    end
    if (st && was_idle) launch_model();
    check("done", 64'(done), 64'(exp_done));
    check("busy", 64'(busy), 64'(exp_busy));
    check("wavefront_num", 64'(wavefront_num), 64'(exp_wf));
`ifdef INST_FETCH_PERF_CNT_EN
    check("stall_cnt", 64'(stall_cnt), 64'(exp_stall_cnt));
    check("bubble_cnt", 64'(bubble_cnt), 64'(exp_bubble_cnt));
`endif
    prev_inst = inst;
  endtask

  task automatic run_until_idle(input int max_cycles, input int stall_pct,
                                input int flush_pct, input int start_pct);
    int n;
    n = 0;
    while (exp_busy && n < max_cycles) begin
      bit s, f, st;
      s  = (int'($urandom_range(0, 99)) < stall_pct);
      f  = (int'($urandom_range(0, 99)) < flush_pct);
      st = (int'($urandom_range(0, 99)) < start_pct);
      if (st) start_wf = 6'($urandom_range(0, 63));
      cycle(s, st, f);
      n++;
    end
    check("launch_finished", 64'(exp_busy), 64'(0));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start_pc = '0; num_inst = '0; start_wf = '0;
    flush = 1'b0; decoder_stall = 1'b0;
    mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = '0;
    rand_mem = 1'b0; gnt_delay = 0; rv_delay = 1; req_age = 0; rv_wait = 0;
    grants = 0; req_cycles = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset = 1'b0;

    // Basic three-word fetch with immediate grant and next-cycle data.
    start_pc = 32'h100; num_inst = 16'd3; start_wf = 6'd5;
    cycle(1'b0, 1'b1, 1'b0);
    run_until_idle(40, 0, 0, 0);
    check("s1_done", 64'(done), 64'(1));
    check("s1_grants", 64'(grants), 64'(3));
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    check("s1_flush_in_done", 64'(state_dbg), 64'(2'd3));

    // Decoder stalled: FIFO fills to depth and requests stop.
    start_pc = 32'h40; num_inst = 16'd8; start_wf = 6'd9;
    cycle(1'b1, 1'b1, 1'b0);
    repeat (10) cycle(1'b1, 1'b0, 1'b0);
    check("s2_full_no_req", 64'(mem_bus.mem_req), 64'(0));
    check("s2_grants_full", 64'(grants), 64'(DEPTH));
    run_until_idle(100, 0, 0, 0);
    check("s2_grants", 64'(grants), 64'(8));

    // Grant delayed three cycles: request held four cycles each.
    gnt_delay = 3;
    start_pc = 32'h200; num_inst = 16'd2; start_wf = 6'd17;
    cycle(1'b0, 1'b1, 1'b0);
    run_until_idle(60, 0, 0, 0);
    check("s3_req_cycles", 64'(req_cycles), 64'(8));
    check("s3_grants", 64'(grants), 64'(2));

    // Flush one cycle after a grant; data arrives two cycles after the flush.
    gnt_delay = 0; rv_delay = 3;
    start_pc = 32'h300; num_inst = 16'd4; start_wf = 6'd12;
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    check("s4_state_flush", 64'(state_dbg), 64'(ST_FLUSH));
    start_wf = 6'd33;
    cycle(1'b0, 1'b1, 1'b0);
    check("s4_still_flush", 64'(state_dbg), 64'(ST_FLUSH));
    cycle(1'b0, 1'b0, 1'b0);
    check("s4_idle", 64'(state_dbg), 64'(ST_IDLE));
    check("s4_inst", 64'(inst), 64'(0));
    cycle(1'b0, 1'b0, 1'b0);

    // Asynchronous reset with two words buffered and a read outstanding.
    rv_delay = 1;
    start_pc = 32'h400; num_inst = 16'd8; start_wf = 6'd3;
    cycle(1'b1, 1'b1, 1'b0);
    repeat (5) cycle(1'b1, 1'b0, 1'b0);
    check("s5_outstanding", 64'(rv_pending), 64'(1));
    #2;
    reset = 1'b1;
    mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0; start = 1'b0;
    #1;
    check_reset_outputs("async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    check("s5_late_rv_ignored", 64'(state_dbg), 64'(ST_IDLE));

    // Zero-length launch goes straight to DONE without requesting.
    start_pc = 32'h500; num_inst = 16'd0; start_wf = 6'd7;
    cycle(1'b0, 1'b1, 1'b0);
    check("s6_done_next", 64'(done), 64'(1));
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    check("s6_no_req", 64'(req_cycles), 64'(0));

    // Randomized launches with random stalls, delays, flushes and ignored starts.
    rand_mem = 1'b1;
    for (int l = 0; l < 15; l++) begin
      start_pc = AW'({$urandom_range(0, 16'h3FFF), 2'b00});
      num_inst = 16'($urandom_range(0, 12));
      start_wf = 6'($urandom_range(0, 63));
      pick_delays();
      cycle(($urandom_range(0, 3) == 0), 1'b1, 1'b0);
      run_until_idle(600, 25, 3, 10);
      repeat (2) cycle(1'b0, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, prefetch FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter ADDR_W, default 32, instruction memory byte-address width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse launching a wavefront fetch.
REQ-006 SHALL have port start_pc  input  ADDR_W  first instruction byte address, word aligned.
REQ-007 SHALL have port num_inst  input  16  instruction count to fetch.
REQ-008 SHALL have port start_wf  input  6  wavefront id for this launch.
REQ-009 SHALL have port flush  input  1  abort current wavefront.
REQ-010 SHALL have port mem_req  output  1  read request valid.
REQ-011 SHALL have port mem_addr  output  ADDR_W  read address.
REQ-012 SHALL have port mem_gnt  input  1  request accepted this cycle.
REQ-013 SHALL have port mem_rvalid  input  1  read data valid.
REQ-014 SHALL have port mem_rdata  input  32  read data.
REQ-015 SHALL have port inst  output  32  instruction to simd32 decoder; 32'h0 = NOP.
REQ-016 SHALL have port wavefront_num  output  6  wavefront id to decoder.
REQ-017 SHALL have port decoder_stall  input  1  decoder cannot accept; inst must hold.
REQ-018 SHALL have port busy  output  1  state is not IDLE/DONE.
REQ-019 SHALL have port done  output  1  high in DONE state.

Function
REQ-020 SHALL implement states IDLE, FETCH, FLUSH, DONE.
REQ-021 IDLE/DONE + start: latch pc=start_pc, remaining=num_inst, wavefront_num=start_wf; go FETCH; num_inst==0 goes directly DONE.
REQ-022 start while FETCH/FLUSH SHALL be ignored.
REQ-023 At most one outstanding memory request; mem_req high only in FETCH when nothing outstanding, issued<num_inst, and FIFO count + returns pending < FIFO_DEPTH.
REQ-024 mem_addr = pc while mem_req; mem_req/mem_addr held until mem_gnt; on gnt pc += 4, issued += 1.
REQ-025 mem_rvalid SHALL push mem_rdata into FIFO, any cycle >=1 after gnt; FIFO never overflows by construction of REQ-023.
REQ-026 Each cycle decoder_stall=0: inst <= FIFO head with pop if non-empty, else inst <= 32'h0; decoder_stall=1: inst and FIFO head held.
REQ-027 Simultaneous push and pop SHALL be supported at any occupancy including full and empty (empty: pushed word is popped next cycle, not same cycle).
REQ-028 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 FETCH -> DONE when all num_inst words received, FIFO empty, last word transferred to inst.
REQ-030 flush in FETCH: FIFO cleared, inst <= 32'h0 next cycle, mem_req dropped unless held ungranted (then dropped anyway); outstanding granted read -> FLUSH, else IDLE.
REQ-031 FLUSH: discard mem_rvalid data, go IDLE on it; start ignored.
REQ-032 flush in IDLE/DONE SHALL have no effect.
REQ-033 Latency: first instruction appears on inst 2 cycles after mem_rvalid (push, then pop/register) when decoder_stall=0.

Reset
REQ-034 reset SHALL asynchronously force IDLE, FIFO empty, outstanding cleared, pc=0, mem_req=0, mem_addr=0, inst=32'h0, wavefront_num=0, busy=0, done=0.
REQ-035 reset mid-fetch SHALL drop any outstanding request; responses arriving in IDLE SHALL be ignored.

Configuration
REQ-036 Macro INST_FETCH_PERF_CNT_EN defined: add outputs stall_cnt[31:0] (cycles decoder_stall=1 while busy) and bubble_cnt[31:0] (cycles busy, decoder_stall=0, FIFO empty), cleared by reset and start, saturating.
REQ-037 Macro undefined: counters and ports absent; behaviour otherwise identical.

Verification
REQ-038 start_pc=0x100, num_inst=3, gnt same cycle, rvalid next cycle, data A,B,C -> addresses 0x100,0x104,0x108; inst sequence A,B,C then 0; done=1.
REQ-039 FIFO_DEPTH=4, decoder_stall=1 for 10 cycles, num_inst=8 -> at most 4 words buffered, mem_req low while full, inst held; after release all 8 in order.
REQ-040 mem_gnt delayed 3 cycles -> mem_req and mem_addr=0x200 stable 4 cycles, one grant, pc advances once.
REQ-041 flush one cycle after grant, rvalid 2 cycles later -> state FLUSH, data discarded, IDLE, inst=0, no FIFO push.
REQ-042 reset asserted mid-FETCH with 2 words buffered -> all outputs reset values immediately; later rvalid ignored.
REQ-043 num_inst=0 start -> DONE next cycle, mem_req never asserted.
